// File: rtl/err_pkg.sv
// Shared types and constants for the line-error calculator.
// Also holds the 17-bit to 16-bit signed saturation helper.
package err_pkg;

    localparam int unsigned IR_W   = 12;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned N_PAIR = 4;
    localparam int unsigned STEP_W = 3;

    localparam logic [ERR_W-1:0] ERR_MAX = 16'h7FFF;
    localparam logic [ERR_W-1:0] ERR_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

    // |accum| never exceeds 2^16, so the top two bits disagreeing means out of 16-bit range
    function automatic logic [ERR_W-1:0] sat_err(input logic [ACC_W-1:0] a);
        logic [ERR_W-1:0] r;
        if (a[ACC_W-1] != a[ACC_W-2]) begin
            r = a[ACC_W-1] ? ERR_MIN : ERR_MAX;
        end else begin
            r = a[ERR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/err_compute.sv
// Weighted right-minus-left line error, one shared add/sub over eight cycles,
// saturated to 16 bits signed and flagged with a one-cycle err_vld pulse.
module err_compute
    import err_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  IR_R0,
    input  logic [IR_W-1:0]  IR_R1,
    input  logic [IR_W-1:0]  IR_R2,
    input  logic [IR_W-1:0]  IR_R3,
    input  logic [IR_W-1:0]  IR_L0,
    input  logic [IR_W-1:0]  IR_L1,
    input  logic [IR_W-1:0]  IR_L2,
    input  logic [IR_W-1:0]  IR_L3,
    input  logic             IR_vld,
    input  logic             line_present,
    output logic [ERR_W-1:0] error,
    output logic             err_vld,
    output logic             busy,
    output logic             ovr
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IR_W-1:0]     w_ir_r [N_PAIR];
    logic [IR_W-1:0]     w_ir_l [N_PAIR];
    logic [IR_W-1:0]     r_snap_r [N_PAIR];
    logic [IR_W-1:0]     r_snap_l [N_PAIR];
    logic                r_snap_lp;

    logic [STEP_W-1:0]   r_step;
    logic [ACC_W-1:0]    r_accum;
    logic [ERR_W-1:0]    r_error;
    logic                r_err_vld;
    logic                r_busy;
    logic                r_ovr;

    logic                w_capture;
    logic                w_acc_en;
    logic                w_sat_en;
    logic                w_drop;
    logic [1:0]          w_pair;
    logic                w_sub;
    logic [ACC_W-1:0]    w_operand;
    logic [ACC_W-1:0]    w_sum;

    assign w_ir_r[0] = IR_R0;
    assign w_ir_r[1] = IR_R1;
    assign w_ir_r[2] = IR_R2;
    assign w_ir_r[3] = IR_R3;
    assign w_ir_l[0] = IR_L0;
    assign w_ir_l[1] = IR_L1;
    assign w_ir_l[2] = IR_L2;
    assign w_ir_l[3] = IR_L3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (IR_vld) w_state_nxt = ACCUM;
            ACCUM:   if (r_step == 3'd7) w_state_nxt = SAT;
            SAT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_acc_en  = 1'b0;
        w_sat_en  = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            IDLE: begin
                w_capture = IR_vld;
            end
            ACCUM: begin
                w_acc_en = 1'b1;
                w_drop   = IR_vld;
            end
            SAT: begin
                w_sat_en = 1'b1;
                w_drop   = IR_vld;
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
    end

    // Shared adder: even steps add R[i]<<i, odd steps subtract L[i]<<i
    assign w_pair    = r_step[2:1];
    assign w_sub     = r_step[0];
    assign w_operand = ACC_W'(w_sub ? r_snap_l[w_pair] : r_snap_r[w_pair]) << w_pair;
    assign w_sum     = r_accum + (w_sub ? ~w_operand : w_operand) + ACC_W'(w_sub);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step    <= '0;
            r_accum   <= '0;
            r_error   <= '0;
            r_err_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_ovr     <= 1'b0;
            r_snap_lp <= 1'b0;
            for (int i = 0; i < N_PAIR; i++) begin
                r_snap_r[i] <= '0;
                r_snap_l[i] <= '0;
            end
        end else begin
            r_err_vld <= w_sat_en;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
            if (w_capture) begin
                r_snap_lp <= line_present;
                r_accum   <= '0;
                r_step    <= '0;
                for (int i = 0; i < N_PAIR; i++) begin
                    r_snap_r[i] <= w_ir_r[i];
                    r_snap_l[i] <= w_ir_l[i];
                end
            end else if (w_acc_en) begin
                r_accum <= w_sum;
                r_step  <= r_step + 3'd1;
            end
            if (w_sat_en) begin
                r_error <= r_snap_lp ? sat_err(r_accum) : '0;
            end
        end
    end

    assign error   = r_error;
    assign err_vld = r_err_vld;
    assign busy    = r_busy;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_err_compute.sv
// Directed and randomized checks of err_compute against an arithmetic
// reference of the weighted right-minus-left error with saturation.
module tb_err_compute;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ir_r [4];
    logic [11:0] ir_l [4];
    logic        ir_vld;
    logic        lp;
    logic [15:0] error;
    logic        err_vld;
    logic        busy;
    logic        ovr;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] prev_err = 16'h0;
    bit          exp_ovr  = 1'b0;

    err_compute dut (
        .clk          (clk),
        .rst          (rst),
        .IR_R0        (ir_r[0]),
        .IR_R1        (ir_r[1]),
        .IR_R2        (ir_r[2]),
        .IR_R3        (ir_r[3]),
        .IR_L0        (ir_l[0]),
        .IR_L1        (ir_l[1]),
        .IR_L2        (ir_l[2]),
        .IR_L3        (ir_l[3]),
        .IR_vld       (ir_vld),
        .line_present (lp),
        .error        (error),
        .err_vld      (err_vld),
        .busy         (busy),
        .ovr          (ovr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: sum of (R_i - L_i) * 2^i, clamped to int16, zero when no line
    function automatic logic [15:0] ref_err(input int r[4], input int l[4], input bit lp_i);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += (r[i] - l[i]) * (1 << i);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (!lp_i) s = 0;
        return 16'(s);
    endfunction

    task automatic clear_in();
        for (int i = 0; i < 4; i++) begin
            ir_r[i] = 12'd0;
            ir_l[i] = 12'd0;
        end
        lp = 1'b1;
    endtask

    task automatic rand_in(input bit extremes);
        for (int i = 0; i < 4; i++) begin
            ir_r[i] = (extremes && $urandom_range(0, 2) == 0) ? 12'hFFF : 12'($urandom);
            ir_l[i] = (extremes && $urandom_range(0, 2) == 0) ? 12'hFFF : 12'($urandom);
        end
        lp = ($urandom_range(0, 7) != 0);
    endtask

    // Issues IR_vld in the current cycle (cycle 0) and checks cycles 1..10
    task automatic run_txn(input string tag, input bit scramble, input int ovr_at);
        int r[4];
        int l[4];
        logic [15:0] exp_err;
        for (int i = 0; i < 4; i++) begin
            r[i] = int'(ir_r[i]);
            l[i] = int'(ir_l[i]);
        end
        exp_err = ref_err(r, l, lp);
        ir_vld = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check({tag, "_busy"}, 32'(busy), 32'(k <= 9));
            check({tag, "_err_vld"}, 32'(err_vld), 32'(k == 10));
            if (k < 10) begin
                check({tag, "_err_hold"}, 32'(error), 32'(prev_err));
            end else begin
                check({tag, "_error"}, 32'(error), 32'(exp_err));
                check({tag, "_ovr"}, 32'(ovr), 32'(exp_ovr));
                prev_err = exp_err;
            end
            ir_vld = (k == ovr_at);
            if (k == ovr_at) exp_ovr = 1'b1;
            if (scramble && k < 10) rand_in(1'b0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ir_vld = 1'b0;
        clear_in();
        step();
        step();
        check("rst_error", 32'(error), 32'h0);
        check("rst_err_vld", 32'(err_vld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        rst = 1'b0;
        step();

        clear_in();
        ir_r[3] = 12'hFFF;
        run_txn("r3_max", 1'b0, 0);
        step();

        clear_in();
        for (int i = 0; i < 4; i++) ir_r[i] = 12'hFFF;
        run_txn("sat_pos", 1'b0, 0);
        step();

        clear_in();
        for (int i = 0; i < 4; i++) ir_l[i] = 12'hFFF;
        run_txn("sat_neg", 1'b0, 0);
        step();

        clear_in();
        ir_r[1] = 12'd100;
        ir_l[1] = 12'd40;
        run_txn("hold_in", 1'b1, 0);
        step();

        clear_in();
        ir_r[3] = 12'hFFF;
        lp = 1'b0;
        run_txn("no_line", 1'b0, 0);
        step();

        rand_in(1'b1);
        run_txn("ovr_drop", 1'b0, 4);
        rand_in(1'b1);
        run_txn("b2b", 1'b0, 0);
        step();

        // Abort at cycle 5 with a synchronous reset
        rand_in(1'b1);
        lp = 1'b1;
        ir_vld = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            ir_vld = 1'b0;
        end
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_err_vld", 32'(err_vld), 32'h0);
        check("abort_error", 32'(error), 32'h0);
        check("abort_ovr", 32'(ovr), 32'h0);
        rst      = 1'b0;
        exp_ovr  = 1'b0;
        prev_err = 16'h0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("abort_quiet", 32'(err_vld), 32'h0);
        end
        rand_in(1'b1);
        run_txn("post_abort", 1'b0, 0);
        step();

        // Reset wins over a coincident IR_vld
        rst    = 1'b1;
        ir_vld = 1'b1;
        step();
        rst    = 1'b0;
        ir_vld = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'h0);
        prev_err = 16'h0;
        step();
        check("rst_prio_idle", 32'(busy), 32'h0);
        check("rst_prio_error", 32'(error), 32'h0);

        for (int n = 0; n < 20; n++) begin
            rand_in(1'b1);
            run_txn("rand", 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
